// File: rtl/stack_op_sequencer_pkg.sv
// Shared definitions for the stack-operation sequencer.
//   ADDR_W / DATA_W / PC_W : data-memory word address, data word and PC widths
//   SP_RESET               : stack pointer value after reset (top of memory)
//   op_t                   : stack operation codes presented on op_type
//   state_t                : sequencer states
package stack_op_sequencer_pkg;

  localparam int unsigned ADDR_W = 20;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned PC_W   = 32;

  localparam logic [ADDR_W-1:0] SP_RESET = 20'hFFFFF;

  typedef enum logic [1:0] {
    OP_CALL = 2'b00,
    OP_RET  = 2'b01,
    OP_INT  = 2'b10,
    OP_RTI  = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PUSH_FLG = 3'd1,
    ST_PUSH_LO  = 3'd2,
    ST_PUSH_HI  = 3'd3,
    ST_POP_HI   = 3'd4,
    ST_POP_LO   = 3'd5,
    ST_POP_FLG  = 3'd6
  } state_t;

endpackage

// File: rtl/stack_op_sequencer_stack_pointer_unit.sv
// Stack pointer register.
//   clk, rst_n : clock, asynchronous active-low reset (SP -> SP_RESET)
//   inc, dec   : increment / decrement enables (inc wins if both set)
//   sp         : current stack pointer
//   sp_plus1   : sp + 1, address of the top-of-stack word for pops
// All arithmetic wraps modulo 2^ADDR_W.
module stack_pointer_unit
  import stack_op_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              dec,
  output logic [ADDR_W-1:0] sp,
  output logic [ADDR_W-1:0] sp_plus1
);

  logic [ADDR_W-1:0] sp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q <= SP_RESET;
    end else if (inc) begin
      sp_q <= sp_q + 20'd1;
    end else if (dec) begin
      sp_q <= sp_q - 20'd1;
    end
  end

  assign sp       = sp_q;
  assign sp_plus1 = sp_q + 20'd1;

endmodule

// File: rtl/stack_op_sequencer.sv
// Stack-operation sequencer: runs CALL / RET / INT / RTI as short sequences of
// 16-bit data-memory pushes and pops on a descending, post-decrement stack.
//   clk, rst_n        : clock, asynchronous active-low reset
//   op_valid, op_type : operation request (accepted only in IDLE)
//   pc_in, flags_in   : return PC and {C,N,Z} captured on acceptance
//   mem_rdata         : combinational read data for the current mem_addr
//   mem_we, mem_re    : data-memory write / read strobes
//   mem_addr          : word address (SP for pushes, SP+1 for pops)
//   mem_wdata         : write data
//   stall             : freeze fetch/decode while a sequence is pending/active
//   pc_out, pc_load   : popped PC and its one-cycle load strobe
//   flags_out, flags_load : popped flags and their one-cycle load strobe
//   done              : high in the final cycle of every sequence
//   sp_out            : current stack pointer
module stack_op_sequencer
  import stack_op_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  input  logic [1:0]        op_type,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [2:0]        flags_in,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              stall,
  output logic [PC_W-1:0]   pc_out,
  output logic              pc_load,
  output logic [2:0]        flags_out,
  output logic              flags_load,
  output logic              done,
  output logic [ADDR_W-1:0] sp_out
);

  state_t            state;
  op_t               op_q;
  logic [PC_W-1:0]   pc_q;
  logic [2:0]        flags_q;
  logic [DATA_W-1:0] hi_q;

  logic              is_push;
  logic              is_pop;
  logic [ADDR_W-1:0] sp;
  logic [ADDR_W-1:0] sp_plus1;

  assign is_push = (state == ST_PUSH_FLG) || (state == ST_PUSH_LO) || (state == ST_PUSH_HI);
  assign is_pop  = (state == ST_POP_HI) || (state == ST_POP_LO) || (state == ST_POP_FLG);

  stack_pointer_unit u_sp (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (is_pop),
    .dec      (is_push),
    .sp       (sp),
    .sp_plus1 (sp_plus1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      op_q    <= OP_CALL;
      pc_q    <= '0;
      flags_q <= '0;
      hi_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (op_valid) begin
            op_q    <= op_t'(op_type);
            pc_q    <= pc_in;
            flags_q <= flags_in;
            case (op_t'(op_type))
              OP_CALL: state <= ST_PUSH_LO;
              OP_INT:  state <= ST_PUSH_FLG;
              default: state <= ST_POP_HI;
            endcase
          end
        end
        ST_PUSH_FLG: state <= ST_PUSH_LO;
        ST_PUSH_LO:  state <= ST_PUSH_HI;
        ST_PUSH_HI:  state <= ST_IDLE;
        ST_POP_HI: begin
          hi_q  <= mem_rdata;
          state <= ST_POP_LO;
        end
        ST_POP_LO:   state <= (op_q == OP_RTI) ? ST_POP_FLG : ST_IDLE;
        ST_POP_FLG:  state <= ST_IDLE;
        default:     state <= ST_IDLE;
      endcase
    end
  end

  // Strobes decode straight from the state register, so the async reset
  // clears them without waiting for a clock; the read-data paths stay
  // combinational because mem_rdata arrives in the same cycle as mem_re.
  always_comb begin
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_wdata  = '0;
    pc_out     = '0;
    pc_load    = 1'b0;
    flags_out  = '0;
    flags_load = 1'b0;
    done       = 1'b0;
    mem_addr   = is_pop ? sp_plus1 : sp;
    case (state)
      ST_PUSH_FLG: begin
        mem_we    = 1'b1;
        mem_wdata = {13'b0, flags_q};
      end
      ST_PUSH_LO: begin
        mem_we    = 1'b1;
        mem_wdata = pc_q[15:0];
      end
      ST_PUSH_HI: begin
        mem_we    = 1'b1;
        mem_wdata = pc_q[31:16];
        done      = 1'b1;
      end
      ST_POP_HI: begin
        mem_re = 1'b1;
      end
      ST_POP_LO: begin
        mem_re  = 1'b1;
        pc_load = 1'b1;
        pc_out  = {hi_q, mem_rdata};
        done    = (op_q != OP_RTI);
      end
      ST_POP_FLG: begin
        mem_re     = 1'b1;
        flags_load = 1'b1;
        flags_out  = mem_rdata[2:0];
        done       = 1'b1;
      end
      default: ;
    endcase
  end

  // Gated by rst_n so stall drops immediately on reset even with op_valid high.
  assign stall  = rst_n & ((state != ST_IDLE) | op_valid);
  assign sp_out = sp;

endmodule

// File: tb/tb_stack_op_sequencer.sv
module tb_stack_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid;
  logic [1:0]  op_type;
  logic [31:0] pc_in;
  logic [2:0]  flags_in;
  logic [15:0] mem_rdata;
  logic        mem_we, mem_re;
  logic [19:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        stall;
  logic [31:0] pc_out;
  logic        pc_load;
  logic [2:0]  flags_out;
  logic        flags_load;
  logic        done;
  logic [19:0] sp_out;

  stack_op_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op_valid   (op_valid),
    .op_type    (op_type),
    .pc_in      (pc_in),
    .flags_in   (flags_in),
    .mem_rdata  (mem_rdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .stall      (stall),
    .pc_out     (pc_out),
    .pc_load    (pc_load),
    .flags_out  (flags_out),
    .flags_load (flags_load),
    .done       (done),
    .sp_out     (sp_out)
  );

  always #5 clk = ~clk;

  // Data memory device attached to the bus.
  logic [15:0] dev [0:1048575];
  always @(posedge clk) if (mem_we) dev[mem_addr] <= mem_wdata;
  assign mem_rdata = mem_re ? dev[mem_addr] : 16'h0000;

  // One bus beat: everything observable in a cycle with any strobe active.
  typedef struct packed {
    logic        we;
    logic        re;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic        pcl;
    logic [31:0] pc;
    logic        fl;
    logic [2:0]  fo;
    logic        dn;
    logic [19:0] sp;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  // Reference model: a word-addressed stack in an associative array with a
  // wrapping 20-bit pointer; push stores at SP then decrements, pop
  // increments then reads.
  logic [15:0] mm [int];
  logic [19:0] msp;

  function automatic logic [15:0] mrd(logic [19:0] a);
    return mm.exists(int'(a)) ? mm[int'(a)] : 16'h0000;
  endfunction

  task automatic m_push(input logic [15:0] v, input logic last);
    beat_t b = '0;
    b.we = 1'b1; b.addr = msp; b.wdata = v; b.dn = last; b.sp = msp;
    mm[int'(msp)] = v;
    msp = msp - 20'd1;
    exp_q.push_back(b);
  endtask

  task automatic m_pop(output beat_t b, output logic [15:0] v);
    b = '0;
    b.re = 1'b1; b.sp = msp;
    msp = msp + 20'd1;
    b.addr = msp;
    v = mrd(msp);
  endtask

  task automatic model_op(input logic [1:0] op, input logic [31:0] pc, input logic [2:0] fl);
    beat_t b;
    logic [15:0] hi, lo, f;
    case (op)
      2'b00: begin m_push(pc[15:0], 1'b0); m_push(pc[31:16], 1'b1); end
      2'b10: begin
        m_push({13'b0, fl}, 1'b0); m_push(pc[15:0], 1'b0); m_push(pc[31:16], 1'b1);
      end
      default: begin
        m_pop(b, hi); exp_q.push_back(b);
        m_pop(b, lo); b.pcl = 1'b1; b.pc = {hi, lo}; b.dn = (op == 2'b01);
        exp_q.push_back(b);
        if (op == 2'b11) begin
          m_pop(b, f); b.fl = 1'b1; b.fo = f[2:0]; b.dn = 1'b1;
          exp_q.push_back(b);
        end
      end
    endcase
  endtask

  // Monitor: every strobe cycle must match the next expected beat.
  always @(negedge clk) begin
    beat_t a, e;
    if (rst_n && (mem_we || mem_re || pc_load || flags_load || done)) begin
      a = '0;
      a.we = mem_we; a.re = mem_re; a.addr = mem_addr;
      a.wdata = mem_we ? mem_wdata : 16'h0;
      a.pcl = pc_load; a.pc = pc_load ? pc_out : 32'h0;
      a.fl = flags_load; a.fo = flags_load ? flags_out : 3'h0;
      a.dn = done; a.sp = sp_out;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat actual=%h required=<none>", a);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL bus_beat t=%0t actual=%h required=%h", $time, a, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] pc, input logic [2:0] fl,
                        input bit hold);
    int ncyc, nstall, len;
    bit got;
    @(negedge clk); #1;
    op_valid = 1'b1; op_type = op; pc_in = pc; flags_in = fl;
    model_op(op, pc, fl);
    len = (op == 2'b00 || op == 2'b01) ? 2 : 3;
    #1 nstall = stall ? 1 : 0;
    @(posedge clk); #1;
    if (!hold) op_valid = 1'b0;
    ncyc = 0; got = 0;
    while (!got && ncyc < 10) begin
      @(negedge clk);
      ncyc++;
      if (stall) nstall++;
      if (done) got = 1;
    end
    if (!got) begin
      errors++;
      $display("FAIL done_timeout actual=none required=done within 10 cycles");
    end
    #1 op_valid = 1'b0;
    chk("seq_length", 64'(ncyc), 64'(len));
    chk("stall_cycles", 64'(nstall), 64'(len + 1));
    @(negedge clk);
    chk("idle_stall", 64'(stall), 64'd0);
    chk("sp_after", 64'(sp_out), 64'(msp));
  endtask

  initial begin
    rst_n = 1'b0; op_valid = 1'b1; op_type = 2'b00; pc_in = '0; flags_in = '0;
    msp = 20'hFFFFF;
    for (int i = 0; i < 1048576; i++) dev[i] = 16'h0000;
    #1 chk("reset_stall_gated", 64'(stall), 64'd0);
    op_valid = 1'b0;
    #20;
    chk("reset_sp", 64'(sp_out), 64'hFFFFF);
    chk("reset_strobes", 64'({mem_we, mem_re, pc_load, flags_load, done}), 64'd0);
    chk("reset_addr_wdata", 64'({mem_addr, mem_wdata}), 64'({20'hFFFFF, 16'h0000}));
    @(negedge clk) rst_n = 1'b1;

    // Directed: CALL/RET pair, INT/RTI pair.
    run_op(2'b00, 32'h1234_5678, 3'b000, 0);
    chk("call_sp", 64'(sp_out), 64'hFFFFD);
    run_op(2'b01, 32'h0, 3'b000, 0);
    chk("ret_sp", 64'(sp_out), 64'hFFFFF);
    run_op(2'b10, 32'h0000_00A0, 3'b101, 0);
    run_op(2'b11, 32'h0, 3'b000, 0);
    chk("rti_sp", 64'(sp_out), 64'hFFFFF);

    // Wrap: RTI pops FFFFF->2, CALL pushes 2,1 -> SP=0, CALL pushes 0,FFFFF.
    run_op(2'b11, 32'h0, 3'b000, 0);
    run_op(2'b00, 32'hCAFE_0001, 3'b000, 0);
    chk("sp_at_zero", 64'(sp_out), 64'h00000);
    run_op(2'b00, 32'hBEEF_0002, 3'b000, 0);
    chk("sp_wrapped", 64'(sp_out), 64'hFFFFE);

    // op_valid held high through a CALL must not retrigger.
    run_op(2'b00, 32'h5555_AAAA, 3'b010, 1);

    // Random mix.
    for (int n = 0; n < 40; n++)
      run_op(2'($urandom_range(0, 3)), $urandom, 3'($urandom_range(0, 7)), bit'($urandom_range(0, 1)));

    // Reset pulse while in PUSH_LO.
    @(negedge clk); #1;
    op_valid = 1'b1; op_type = 2'b00; pc_in = 32'h7777_8888;
    model_op(2'b00, 32'h7777_8888, 3'b000);
    @(posedge clk); #1 op_valid = 1'b0;
    @(negedge clk); #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_we", 64'(mem_we), 64'd0);
    chk("rst_mid_stall", 64'(stall), 64'd0);
    chk("rst_mid_sp", 64'(sp_out), 64'hFFFFF);
    exp_q.delete();
    msp = 20'hFFFFF;
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_we", 64'(mem_we), 64'd0);
    chk("post_rst_sp", 64'(sp_out), 64'hFFFFF);
    @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
